// File: rtl/ariane_ace_pkg.sv
// Shared ACE snoop-channel definitions: field widths, CRRESP bit positions
// and the snoop sequencer FSM state encoding.
package ariane_ace;

  localparam int unsigned AcSnoopWidth       = 4;
  localparam int unsigned AcProtWidth        = 3;
  localparam int unsigned CrRespWidth        = 5;
  localparam int unsigned CrRespDataTransfer = 0;
  localparam int unsigned CrRespError        = 1;

  typedef enum logic [1:0] {
    SNP_IDLE    = 2'd0,
    SNP_ISSUE   = 2'd1,
    SNP_WAIT_CR = 2'd2,
    SNP_DATA    = 2'd3
  } snp_state_e;

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO with registered head. Push is allowed while full
// only when a pop happens in the same cycle.
module fifo_v3 #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]         cnt_q, cnt_d;
  logic                  push_ok, pop_ok;

  assign full_o  = (cnt_q == (PtrW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH-1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH-1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + (PtrW+1)'(1);
    end else if (pop_ok && !push_ok) begin
      cnt_d = cnt_q - (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: contents are only observed when cnt_q says so.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/ace_snoop_sequencer.sv
// Serialises AC snoops into the cache one at a time, registers the CR
// response and passes the CD burst through while checking its beat count.
module ace_snoop_sequencer
  import ariane_ace::*;
#(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned CdBeats   = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    ac_valid_i,
  output logic                    ac_ready_o,
  input  logic [AddrWidth-1:0]    ac_addr_i,
  input  logic [AcSnoopWidth-1:0] ac_snoop_i,
  input  logic [AcProtWidth-1:0]  ac_prot_i,
  output logic                    cr_valid_o,
  input  logic                    cr_ready_i,
  output logic [CrRespWidth-1:0]  cr_resp_o,
  output logic                    cd_valid_o,
  input  logic                    cd_ready_i,
  output logic [DataWidth-1:0]    cd_data_o,
  output logic                    cd_last_o,
  output logic                    snp_ac_valid_o,
  input  logic                    snp_ac_ready_i,
  output logic [AddrWidth-1:0]    snp_ac_addr_o,
  output logic [AcSnoopWidth-1:0] snp_ac_snoop_o,
  output logic [AcProtWidth-1:0]  snp_ac_prot_o,
  input  logic                    snp_cr_valid_i,
  output logic                    snp_cr_ready_o,
  input  logic [CrRespWidth-1:0]  snp_cr_resp_i,
  input  logic                    snp_cd_valid_i,
  output logic                    snp_cd_ready_o,
  input  logic [DataWidth-1:0]    snp_cd_data_i,
  input  logic                    snp_cd_last_i,
  output logic                    busy_o,
  output logic                    err_o,
  output snp_state_e              dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never drops and payload never changes until that edge.

  localparam int unsigned CntW = (CdBeats > 1) ? $clog2(CdBeats) : 1;
  localparam int unsigned AcW  = AddrWidth + AcSnoopWidth + AcProtWidth;

  snp_state_e             state_q, state_d;
  logic [CntW-1:0]        beat_q, beat_d;
  logic                   cr_full_q, cr_full_d;
  logic [CrRespWidth-1:0] cr_resp_q, cr_resp_d;
  logic                   err_q, err_d;
  logic                   fifo_full, fifo_empty, fifo_pop, cr_load, cd_hs, last_beat;
  logic [AcW-1:0]         fifo_head;

  fifo_v3 #(
    .DEPTH      (2),
    .DATA_WIDTH (AcW)
  ) i_ac_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (ac_valid_i && ac_ready_o),
    .pop_i   (fifo_pop),
    .data_i  ({ac_prot_i, ac_snoop_i, ac_addr_i}),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign ac_ready_o = !fifo_full;
  assign {snp_ac_prot_o, snp_ac_snoop_o, snp_ac_addr_o} = fifo_head;
  assign cd_data_o   = snp_cd_data_i;
  assign cr_valid_o  = cr_full_q;
  assign cr_resp_o   = cr_resp_q;
  assign err_o       = err_q;
  assign dbg_state_o = state_q;
  assign last_beat   = (beat_q == CntW'(CdBeats - 1));
  assign busy_o      = (state_q != SNP_IDLE) || !fifo_empty || cr_full_q;

  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    fifo_pop       = 1'b0;
    cr_load        = 1'b0;
    cd_hs          = 1'b0;
    snp_ac_valid_o = 1'b0;
    snp_cr_ready_o = 1'b0;
    snp_cd_ready_o = 1'b0;
    cd_valid_o     = 1'b0;
    cd_last_o      = 1'b0;
    unique case (state_q)
      SNP_IDLE: begin
        if (!fifo_empty) state_d = SNP_ISSUE;
      end
      SNP_ISSUE: begin
        snp_ac_valid_o = 1'b1;
        if (snp_ac_ready_i) begin
          fifo_pop = 1'b1;
          state_d  = SNP_WAIT_CR;
        end
      end
      SNP_WAIT_CR: begin
        // Response waits in the cache while the previous one is undelivered.
        snp_cr_ready_o = !cr_full_q;
        if (snp_cr_valid_i && !cr_full_q) begin
          cr_load = 1'b1;
          if (snp_cr_resp_i[CrRespDataTransfer]) begin
            state_d = SNP_DATA;
            beat_d  = '0;
          end else begin
            state_d = SNP_IDLE;
          end
        end
      end
      SNP_DATA: begin
        cd_valid_o     = snp_cd_valid_i;
        cd_last_o      = snp_cd_last_i;
        snp_cd_ready_o = cd_ready_i;
        if (snp_cd_valid_i && cd_ready_i) begin
          cd_hs = 1'b1;
          if (last_beat) begin
            beat_d  = '0;
            state_d = SNP_IDLE;
          end else begin
            beat_d = beat_q + CntW'(1);
          end
        end
      end
      default: state_d = SNP_IDLE;
    endcase
  end

  always_comb begin
    cr_full_d = cr_full_q;
    cr_resp_d = cr_resp_q;
    if (cr_load) begin
      cr_full_d = 1'b1;
      cr_resp_d = snp_cr_resp_i;
    end else if (cr_full_q && cr_ready_i) begin
      cr_full_d = 1'b0;
    end
    err_d = err_q
          || (cd_hs && (snp_cd_last_i != last_beat))
          || (snp_cd_valid_i && (state_q != SNP_DATA))
          || (snp_cr_valid_i && ((state_q == SNP_IDLE) || (state_q == SNP_ISSUE)));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= SNP_IDLE;
      beat_q    <= '0;
      cr_full_q <= 1'b0;
      cr_resp_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      cr_full_q <= cr_full_d;
      cr_resp_q <= cr_resp_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_ace_snoop_sequencer.sv
// Bench for ace_snoop_sequencer: interconnect and cache models driven at
// random, checked against a transaction-level reference model.
module tb_ace_snoop_sequencer;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int CdBeats = 2;
  localparam int ACW = AW + 7;

  logic clk = 1'b0;
  logic rst_i;
  logic ac_valid_i, ac_ready_o;
  logic [AW-1:0] ac_addr_i;
  logic [3:0] ac_snoop_i;
  logic [2:0] ac_prot_i;
  logic cr_valid_o, cr_ready_i;
  logic [4:0] cr_resp_o;
  logic cd_valid_o, cd_ready_i, cd_last_o;
  logic [DW-1:0] cd_data_o;
  logic snp_ac_valid_o, snp_ac_ready_i;
  logic [AW-1:0] snp_ac_addr_o;
  logic [3:0] snp_ac_snoop_o;
  logic [2:0] snp_ac_prot_o;
  logic snp_cr_valid_i, snp_cr_ready_o;
  logic [4:0] snp_cr_resp_i;
  logic snp_cd_valid_i, snp_cd_ready_o, snp_cd_last_i;
  logic [DW-1:0] snp_cd_data_i;
  logic busy_o, err_o;
  ariane_ace::snp_state_e dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  ace_snoop_sequencer #(.AddrWidth(AW), .DataWidth(DW), .CdBeats(CdBeats)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o), .ac_addr_i(ac_addr_i),
    .ac_snoop_i(ac_snoop_i), .ac_prot_i(ac_prot_i),
    .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_resp_o(cr_resp_o),
    .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i), .cd_data_o(cd_data_o), .cd_last_o(cd_last_o),
    .snp_ac_valid_o(snp_ac_valid_o), .snp_ac_ready_i(snp_ac_ready_i), .snp_ac_addr_o(snp_ac_addr_o),
    .snp_ac_snoop_o(snp_ac_snoop_o), .snp_ac_prot_o(snp_ac_prot_o),
    .snp_cr_valid_i(snp_cr_valid_i), .snp_cr_ready_o(snp_cr_ready_o), .snp_cr_resp_i(snp_cr_resp_i),
    .snp_cd_valid_i(snp_cd_valid_i), .snp_cd_ready_o(snp_cd_ready_o),
    .snp_cd_data_i(snp_cd_data_i), .snp_cd_last_i(snp_cd_last_i),
    .busy_o(busy_o), .err_o(err_o), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int unsigned n_cmp = 0, n_bad = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [ACW-1:0] exp_ac_q[$];   // accepted, not yet issued to the cache
  logic [4:0]     exp_cr_q[$];   // responses taken from the cache, not yet delivered
  logic [ACW-1:0] ac_stim_q[$];  // directed requests for the interconnect driver
  int  m_fifo_cnt, m_beats_left, m_beat_idx, n_cr_out, n_beats_out;
  bit  m_pending, exp_err, ac_fired, scr_fired, scd_fired;
  bit  busy_exp, issue_ok, ac_hs, sac_hs, scr_hs, cr_hs, cd_hs;

  // Model state: snoops wait in order, at most one is with the cache, at most
  // one response waits for the interconnect, a data response owes CdBeats beats.
  always @(negedge clk) begin
    if (rst_i) begin
      exp_ac_q.delete(); exp_cr_q.delete();
      m_fifo_cnt = 0; m_beats_left = 0; m_beat_idx = 0; m_pending = 0; exp_err = 0;
      ac_fired = 0; scr_fired = 0; scd_fired = 0;
    end else begin
      busy_exp = (m_fifo_cnt != 0) || m_pending || (m_beats_left != 0) || (exp_cr_q.size() != 0);
      issue_ok = (m_fifo_cnt != 0) && !m_pending && (m_beats_left == 0);
      check_eq("ac_ready", ac_ready_o, m_fifo_cnt < 2);
      check_eq("busy", busy_o, busy_exp);
      check_eq("err", err_o, exp_err);
      check_eq("cr_valid", cr_valid_o, exp_cr_q.size() != 0);
      if (exp_cr_q.size() != 0) check_eq("cr_resp", cr_resp_o, exp_cr_q[0]);
      check_eq("snp_cr_ready", snp_cr_ready_o, m_pending && (exp_cr_q.size() == 0));
      check_eq("cd_valid", cd_valid_o, (m_beats_left > 0) && snp_cd_valid_i);
      check_eq("snp_cd_ready", snp_cd_ready_o, (m_beats_left > 0) && cd_ready_i);
      if (!issue_ok) check_eq("snp_ac_valid_idle", snp_ac_valid_o, 1'b0);
      else if (snp_ac_valid_o)
        check_eq("snp_ac_fields", {snp_ac_prot_o, snp_ac_snoop_o, snp_ac_addr_o}, exp_ac_q[0]);

      ac_hs  = ac_valid_i && ac_ready_o && (m_fifo_cnt < 2);
      sac_hs = snp_ac_valid_o && snp_ac_ready_i && issue_ok;
      scr_hs = snp_cr_valid_i && snp_cr_ready_o && m_pending;
      cr_hs  = cr_valid_o && cr_ready_i && (exp_cr_q.size() != 0);
      cd_hs  = (m_beats_left > 0) && snp_cd_valid_i && cd_ready_i;

      if (cd_hs) begin
        check_eq("cd_data", cd_data_o, snp_cd_data_i);
        check_eq("cd_last", cd_last_o, snp_cd_last_i);
        if (snp_cd_last_i != (m_beat_idx == CdBeats - 1)) exp_err = 1;
      end
      if (snp_cd_valid_i && m_beats_left == 0) exp_err = 1;
      if (snp_cr_valid_i && !m_pending && m_beats_left == 0) exp_err = 1;

      if (ac_hs) begin exp_ac_q.push_back({ac_prot_i, ac_snoop_i, ac_addr_i}); m_fifo_cnt++; end
      if (sac_hs) begin void'(exp_ac_q.pop_front()); m_fifo_cnt--; m_pending = 1; end
      if (cr_hs) begin void'(exp_cr_q.pop_front()); n_cr_out++; end
      if (scr_hs) begin
        exp_cr_q.push_back(snp_cr_resp_i);
        m_pending = 0;
        if (snp_cr_resp_i[0]) begin m_beats_left = CdBeats; m_beat_idx = 0; end
      end
      if (cd_hs) begin m_beat_idx++; m_beats_left--; n_beats_out++; end
      ac_fired = ac_hs; scr_fired = scr_hs; scd_fired = cd_hs;
    end
  end

  // ---------------- driver tasks ----------------
  int p_ac, p_sar, p_crr, p_cdr, p_cache;
  bit cfg_fixed, cfg_bad_last;
  logic [4:0] cfg_resp;

  function automatic bit roll(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  task automatic drive_cycle();
    @(posedge clk); #1;
    if (!(ac_valid_i && !ac_fired)) begin
      if (ac_stim_q.size() != 0) begin
        {ac_prot_i, ac_snoop_i, ac_addr_i} = ac_stim_q.pop_front();
        ac_valid_i = 1;
      end else if (roll(p_ac)) begin
        ac_addr_i  = {$urandom, $urandom};
        ac_snoop_i = 4'($urandom_range(15));
        ac_prot_i  = 3'($urandom_range(7));
        ac_valid_i = 1;
      end else ac_valid_i = 0;
    end
    snp_ac_ready_i = roll(p_sar);
    cr_ready_i     = roll(p_crr);
    cd_ready_i     = roll(p_cdr);
    if (!(snp_cr_valid_i && !scr_fired)) begin
      snp_cr_valid_i = m_pending && roll(p_cache);
      snp_cr_resp_i  = cfg_fixed ? cfg_resp : 5'($urandom_range(31));
    end
    if (!(snp_cd_valid_i && !scd_fired)) begin
      snp_cd_valid_i = (m_beats_left > 0) && roll(p_cache);
      snp_cd_data_i  = {$urandom, $urandom};
      snp_cd_last_i  = cfg_bad_last ? (m_beat_idx == 0) : (m_beat_idx == CdBeats - 1);
    end
  endtask

  task automatic clear_inputs();
    ac_valid_i = 0; ac_addr_i = '0; ac_snoop_i = '0; ac_prot_i = '0;
    cr_ready_i = 0; cd_ready_i = 0; snp_ac_ready_i = 0;
    snp_cr_valid_i = 0; snp_cr_resp_i = '0;
    snp_cd_valid_i = 0; snp_cd_data_i = '0; snp_cd_last_i = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    clear_inputs(); ac_stim_q.delete(); rst_i = 1;
    @(posedge clk); #1;
    rst_i = 0;
  endtask

  task automatic set_probs(input int a, input int sar, input int crr, input int cdr, input int cache);
    p_ac = a; p_sar = sar; p_crr = crr; p_cdr = cdr; p_cache = cache;
  endtask

  // ---------------- stimulus ----------------
  int base_cr, base_beats;
  bit reached;

  initial begin
    clear_inputs();
    rst_i = 1;
    n_cr_out = 0; n_beats_out = 0;
    cfg_fixed = 1; cfg_resp = 5'b00000; cfg_bad_last = 0;
    set_probs(0, 100, 100, 100, 100);
    repeat (3) @(posedge clk);
    #1 rst_i = 0;
    check_eq("rst_ac_ready", ac_ready_o, 1'b1);
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_err", err_o, 1'b0);
    check_eq("rst_cr_valid", cr_valid_o, 1'b0);
    check_eq("rst_snp_ac_valid", snp_ac_valid_o, 1'b0);

    // ReadShared, response without data
    base_cr = n_cr_out; base_beats = n_beats_out;
    ac_stim_q.push_back({3'b010, 4'b0001, 64'h0000_1234_5678_9ac0});
    repeat (12) drive_cycle();
    check_eq("t1_cr_count", n_cr_out - base_cr, 1);
    check_eq("t1_no_data", n_beats_out - base_beats, 0);
    check_eq("t1_idle", busy_o, 1'b0);

    // ReadUnique with a two-beat data response
    cfg_resp = 5'b00001; base_cr = n_cr_out; base_beats = n_beats_out;
    ac_stim_q.push_back({3'b000, 4'b0111, 64'hdead_beef_0000_0040});
    repeat (15) drive_cycle();
    check_eq("t2_cr_count", n_cr_out - base_cr, 1);
    check_eq("t2_beats", n_beats_out - base_beats, CdBeats);
    check_eq("t2_err", err_o, 1'b0);

    // Three requests while the cache stalls
    cfg_resp = 5'b00000; base_cr = n_cr_out; p_sar = 0;
    for (int i = 0; i < 3; i++) ac_stim_q.push_back({3'(i), 4'(i + 1), 64'(64'h1000 * (i + 1))});
    repeat (6) drive_cycle();
    check_eq("t3_full", ac_ready_o, 1'b0);
    p_sar = 100;
    repeat (30) drive_cycle();
    check_eq("t3_cr_count", n_cr_out - base_cr, 3);

    // Interconnect holds off CR while the next snoop waits for its response
    base_cr = n_cr_out; p_crr = 0;
    ac_stim_q.push_back({3'b001, 4'b0001, 64'h2000});
    ac_stim_q.push_back({3'b011, 4'b1001, 64'h3000});
    repeat (10) drive_cycle();
    check_eq("t4_cr_held", cr_valid_o, 1'b1);
    check_eq("t4_cache_blocked", snp_cr_ready_o, 1'b0);
    check_eq("t4_none_out", n_cr_out - base_cr, 0);
    p_crr = 100;
    repeat (10) drive_cycle();
    check_eq("t4_cr_count", n_cr_out - base_cr, 2);

    // Early last beat, then CD valid while idle
    cfg_resp = 5'b00001; cfg_bad_last = 1;
    ac_stim_q.push_back({3'b000, 4'b0111, 64'h4000});
    repeat (12) drive_cycle();
    check_eq("t5_err_set", err_o, 1'b1);
    cfg_bad_last = 0;
    repeat (5) drive_cycle();
    check_eq("t5_err_held", err_o, 1'b1);
    do_reset();
    check_eq("t5_err_cleared", err_o, 1'b0);
    snp_cd_valid_i = 1;
    @(posedge clk); #1;
    snp_cd_valid_i = 0;
    check_eq("t5_err_idle_cd", err_o, 1'b1);
    do_reset();

    // Reset in the middle of a data burst, then a clean snoop
    reached = 0;
    ac_stim_q.push_back({3'b000, 4'b0111, 64'h5000});
    for (int i = 0; i < 30 && !reached; i++) begin
      drive_cycle();
      @(negedge clk); #1;
      if (m_beat_idx == 1 && m_beats_left == CdBeats - 1) reached = 1;
    end
    check_eq("t6_reached_data", reached, 1'b1);
    do_reset();
    check_eq("t6_busy", busy_o, 1'b0);
    check_eq("t6_cr_valid", cr_valid_o, 1'b0);
    check_eq("t6_err", err_o, 1'b0);
    check_eq("t6_ac_ready", ac_ready_o, 1'b1);
    base_cr = n_cr_out; base_beats = n_beats_out;
    ac_stim_q.push_back({3'b000, 4'b0111, 64'h6000});
    repeat (15) drive_cycle();
    check_eq("t6_cr_count", n_cr_out - base_cr, 1);
    check_eq("t6_beats", n_beats_out - base_beats, CdBeats);

    // Random traffic with a legal cache, then drain
    cfg_fixed = 0;
    set_probs(40, 60, 50, 50, 60);
    repeat (3000) drive_cycle();
    set_probs(0, 100, 100, 100, 100);
    for (int i = 0; i < 200; i++) begin
      drive_cycle();
      if (!busy_o && !ac_valid_i && exp_cr_q.size() == 0 && m_fifo_cnt == 0) break;
    end
    check_eq("rand_drained", busy_o, 1'b0);
    check_eq("rand_model_empty", m_fifo_cnt + exp_cr_q.size() + m_beats_left, 0);
    check_eq("rand_err", err_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
